// File: rtl/axi_1x2_addr_demux_if.sv
// Bundle of one AXI-lite-burst port (AR/R/AW/W/B) used for the upstream master and both slaves.
// master drives requests; slave drives responses.
interface axi_1x2_addr_demux_if;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arlen, arsize, arvalid, rready,
    output awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rlast, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arvalid, rready,
    input  awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rlast, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/axi_1x2_addr_demux.sv
// 1:2 address-decoded demux (MEM / CONF) with independent read and write routing FSMs.
// Optional decode-error responder enabled by defining DEMUX_DECERR_EN.
module axi_1x2_addr_demux #(
  parameter logic [31:0] CONF_BASE = 32'h1faf_0000,
  parameter logic [31:0] CONF_MASK = 32'hffff_0000
`ifdef DEMUX_DECERR_EN
  ,
  parameter logic [31:0] ERR_DATA  = 32'hdead_beef,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MEM_MASK  = 32'he000_0000
`endif
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axi_1x2_addr_demux_if.slave     up,
  axi_1x2_addr_demux_if.master    mem,
  axi_1x2_addr_demux_if.master    conf
);

`ifdef DEMUX_DECERR_EN
  typedef enum logic [1:0] {R_IDLE, R_BUSY, R_ERR} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP, W_ERR_DATA} w_state_t;
`else
  typedef enum logic {R_IDLE, R_BUSY} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
`endif

  r_state_t r_state_reg, r_state_next;
  w_state_t w_state_reg, w_state_next;
  logic     rsel_reg, rsel_next;   // 1 = CONF, 0 = MEM
  logic     wsel_reg, wsel_next;

  logic ar_conf, aw_conf;
  assign ar_conf = ((up.araddr & CONF_MASK) == (CONF_BASE & CONF_MASK));
  assign aw_conf = ((up.awaddr & CONF_MASK) == (CONF_BASE & CONF_MASK));

`ifdef DEMUX_DECERR_EN
  logic       ar_mem, aw_mem;
  logic [3:0] rcnt_reg, rcnt_next;
  logic [3:0] rlen_reg, rlen_next;
  logic       werr_reg, werr_next;
  assign ar_mem = ((up.araddr & MEM_MASK) == (MEM_BASE & MEM_MASK));
  assign aw_mem = ((up.awaddr & MEM_MASK) == (MEM_BASE & MEM_MASK));
`endif

  // Payloads fan out to both slaves; only valid/ready are steered.
  assign mem.araddr  = up.araddr;   assign conf.araddr  = up.araddr;
  assign mem.arlen   = up.arlen;    assign conf.arlen   = up.arlen;
  assign mem.arsize  = up.arsize;   assign conf.arsize  = up.arsize;
  assign mem.awaddr  = up.awaddr;   assign conf.awaddr  = up.awaddr;
  assign mem.awlen   = up.awlen;    assign conf.awlen   = up.awlen;
  assign mem.awsize  = up.awsize;   assign conf.awsize  = up.awsize;
  assign mem.wdata   = up.wdata;    assign conf.wdata   = up.wdata;
  assign mem.wstrb   = up.wstrb;    assign conf.wstrb   = up.wstrb;
  assign mem.wlast   = up.wlast;    assign conf.wlast   = up.wlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_reg <= R_IDLE;
      w_state_reg <= W_IDLE;
      rsel_reg    <= 1'b0;
      wsel_reg    <= 1'b0;
`ifdef DEMUX_DECERR_EN
      rcnt_reg    <= 4'd0;
      rlen_reg    <= 4'd0;
      werr_reg    <= 1'b0;
`endif
    end else begin
      r_state_reg <= r_state_next;
      w_state_reg <= w_state_next;
      rsel_reg    <= rsel_next;
      wsel_reg    <= wsel_next;
`ifdef DEMUX_DECERR_EN
      rcnt_reg    <= rcnt_next;
      rlen_reg    <= rlen_next;
      werr_reg    <= werr_next;
`endif
    end
  end

  // Read path
  logic        ar_rdy, r_valid, r_last;
  logic [31:0] r_data;
  always_comb begin
    r_state_next = r_state_reg;
    rsel_next    = rsel_reg;
    ar_rdy       = 1'b0;
    r_valid      = 1'b0;
    r_last       = 1'b0;
    r_data       = 32'd0;
    mem.arvalid  = 1'b0;
    conf.arvalid = 1'b0;
    mem.rready   = 1'b0;
    conf.rready  = 1'b0;
`ifdef DEMUX_DECERR_EN
    rcnt_next    = rcnt_reg;
    rlen_next    = rlen_reg;
`endif
    case (r_state_reg)
      R_IDLE: begin
        if (ar_conf) begin
          conf.arvalid = up.arvalid;
          ar_rdy       = conf.arready;
        end
`ifdef DEMUX_DECERR_EN
        else if (!ar_mem) begin
          ar_rdy = 1'b1;
        end
`endif
        else begin
          mem.arvalid = up.arvalid;
          ar_rdy      = mem.arready;
        end
        if (up.arvalid && ar_rdy) begin
          rsel_next    = ar_conf;
          r_state_next = R_BUSY;
`ifdef DEMUX_DECERR_EN
          if (!ar_conf && !ar_mem) begin
            r_state_next = R_ERR;
            rcnt_next    = 4'd0;
            rlen_next    = up.arlen;
          end
`endif
        end
      end
      R_BUSY: begin
        if (rsel_reg) begin
          r_valid     = conf.rvalid;
          r_last      = conf.rlast;
          r_data      = conf.rdata;
          conf.rready = up.rready;
        end else begin
          r_valid     = mem.rvalid;
          r_last      = mem.rlast;
          r_data      = mem.rdata;
          mem.rready  = up.rready;
        end
        if (r_valid && up.rready && r_last)
          r_state_next = R_IDLE;
      end
`ifdef DEMUX_DECERR_EN
      R_ERR: begin
        r_valid = 1'b1;
        r_data  = ERR_DATA;
        r_last  = (rcnt_reg == rlen_reg);
        if (up.rready) begin
          rcnt_next = rcnt_reg + 4'd1;
          if (r_last)
            r_state_next = R_IDLE;
        end
      end
`endif
      default: r_state_next = R_IDLE;
    endcase
    up.arready = ar_rdy;
    up.rvalid  = r_valid;
    up.rlast   = r_last;
    up.rdata   = r_data;
    if (!aresetn) begin
      up.arready   = 1'b0;
      up.rvalid    = 1'b0;
      up.rlast     = 1'b0;
      up.rdata     = 32'd0;
      mem.arvalid  = 1'b0;
      conf.arvalid = 1'b0;
      mem.rready   = 1'b0;
      conf.rready  = 1'b0;
    end
  end

  // Write path
  logic aw_rdy, w_rdy, b_val;
  always_comb begin
    w_state_next = w_state_reg;
    wsel_next    = wsel_reg;
    aw_rdy       = 1'b0;
    w_rdy        = 1'b0;
    b_val        = 1'b0;
    mem.awvalid  = 1'b0;
    conf.awvalid = 1'b0;
    mem.wvalid   = 1'b0;
    conf.wvalid  = 1'b0;
    mem.bready   = 1'b0;
    conf.bready  = 1'b0;
`ifdef DEMUX_DECERR_EN
    werr_next    = werr_reg;
`endif
    case (w_state_reg)
      W_IDLE: begin
        if (aw_conf) begin
          conf.awvalid = up.awvalid;
          aw_rdy       = conf.awready;
        end
`ifdef DEMUX_DECERR_EN
        else if (!aw_mem) begin
          aw_rdy = 1'b1;
        end
`endif
        else begin
          mem.awvalid = up.awvalid;
          aw_rdy      = mem.awready;
        end
        if (up.awvalid && aw_rdy) begin
          wsel_next    = aw_conf;
          w_state_next = W_DATA;
`ifdef DEMUX_DECERR_EN
          werr_next = !aw_conf && !aw_mem;
          if (!aw_conf && !aw_mem)
            w_state_next = W_ERR_DATA;
`endif
        end
      end
      W_DATA: begin
        if (wsel_reg) begin
          conf.wvalid = up.wvalid;
          w_rdy       = conf.wready;
        end else begin
          mem.wvalid  = up.wvalid;
          w_rdy       = mem.wready;
        end
        if (up.wvalid && w_rdy && up.wlast)
          w_state_next = W_RESP;
      end
`ifdef DEMUX_DECERR_EN
      W_ERR_DATA: begin
        w_rdy = 1'b1;
        if (up.wvalid && up.wlast)
          w_state_next = W_RESP;
      end
`endif
      W_RESP: begin
`ifdef DEMUX_DECERR_EN
        if (werr_reg)
          b_val = 1'b1;
        else
`endif
        if (wsel_reg) begin
          b_val       = conf.bvalid;
          conf.bready = up.bready;
        end else begin
          b_val       = mem.bvalid;
          mem.bready  = up.bready;
        end
        if (b_val && up.bready)
          w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
    up.awready = aw_rdy;
    up.wready  = w_rdy;
    up.bvalid  = b_val;
    if (!aresetn) begin
      up.awready   = 1'b0;
      up.wready    = 1'b0;
      up.bvalid    = 1'b0;
      mem.awvalid  = 1'b0;
      conf.awvalid = 1'b0;
      mem.wvalid   = 1'b0;
      conf.wvalid  = 1'b0;
      mem.bready   = 1'b0;
      conf.bready  = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_1x2_addr_demux.sv
// Directed bench for axi_1x2_addr_demux: drives the upstream port and plays both slaves.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_axi_1x2_addr_demux;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int checks = 0;
  int failures = 0;

  axi_1x2_addr_demux_if up_if ();
  axi_1x2_addr_demux_if mem_if ();
  axi_1x2_addr_demux_if conf_if ();

  axi_1x2_addr_demux dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .up      (up_if.slave),
    .mem     (mem_if.master),
    .conf    (conf_if.master)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // Gap cycles inserted by MEM before each of the 8 beats in the burst test
  int gaps [8] = '{0, 2, 0, 1, 3, 0, 1, 0};

  initial begin
    up_if.araddr = 0; up_if.arlen = 0; up_if.arsize = 3'd2; up_if.arvalid = 0; up_if.rready = 0;
    up_if.awaddr = 0; up_if.awlen = 0; up_if.awsize = 3'd2; up_if.awvalid = 0;
    up_if.wdata = 0; up_if.wstrb = 4'hf; up_if.wlast = 0; up_if.wvalid = 0; up_if.bready = 0;
    mem_if.arready = 0; mem_if.rdata = 0; mem_if.rlast = 0; mem_if.rvalid = 0;
    mem_if.awready = 0; mem_if.wready = 0; mem_if.bvalid = 0;
    conf_if.arready = 0; conf_if.rdata = 0; conf_if.rlast = 0; conf_if.rvalid = 0;
    conf_if.awready = 0; conf_if.wready = 0; conf_if.bvalid = 0;

    // Reset: outputs held at zero even with upstream and slaves active
    up_if.arvalid = 1; up_if.araddr = 32'h1faf_0000; conf_if.arready = 1;
    mem_if.rdata = 32'h5555_5555; mem_if.rvalid = 1; up_if.rready = 1;
    cyc(); cyc();
    check("rst_arready", up_if.arready, 0);
    check("rst_conf_arvalid", conf_if.arvalid, 0);
    check("rst_rdata", up_if.rdata, 0);
    check("rst_rvalid", up_if.rvalid, 0);
    up_if.arvalid = 0; mem_if.rvalid = 0; mem_if.rdata = 0;
    aresetn = 1;
    cyc();

    // 1: single-beat CONF read
    up_if.araddr = 32'h1faf_f020; up_if.arlen = 0; up_if.arvalid = 1;
    conf_if.arready = 1; mem_if.arready = 1;
    #1;
    check("t1_conf_arvalid", conf_if.arvalid, 1);
    check("t1_mem_arvalid", mem_if.arvalid, 0);
    check("t1_arready", up_if.arready, 1);
    cyc();
    up_if.arvalid = 0;
    conf_if.rvalid = 1; conf_if.rdata = 32'h1234; conf_if.rlast = 1;
    mem_if.rvalid = 1; mem_if.rdata = 32'haaaa; up_if.rready = 1;
    #1;
    check("t1_rvalid", up_if.rvalid, 1);
    check("t1_rdata", up_if.rdata, 32'h1234);
    check("t1_rlast", up_if.rlast, 1);
    check("t1_mem_rready", mem_if.rready, 0);
    check("t1_conf_rready", conf_if.rready, 1);
    cyc();
    conf_if.rvalid = 0; conf_if.rlast = 0; mem_if.rvalid = 0;

    // 2: 8-beat MEM read with gaps; a second AR waits behind it
    up_if.araddr = 32'h0000_1000; up_if.arlen = 4'd7; up_if.arvalid = 1;
    #1;
    check("t2_mem_arvalid", mem_if.arvalid, 1);
    check("t2_conf_arvalid", conf_if.arvalid, 0);
    check("t2_arready", up_if.arready, 1);
    cyc();
    up_if.araddr = 32'h0000_2000;
    for (int b = 0; b < 8; b++) begin
      for (int g = 0; g < gaps[b]; g++) begin
        mem_if.rvalid = 0;
        #1;
        check("t2_gap_rvalid", up_if.rvalid, 0);
        check("t2_gap_arready", up_if.arready, 0);
        cyc();
      end
      mem_if.rvalid = 1; mem_if.rdata = 32'h100 + b; mem_if.rlast = (b == 7);
      #1;
      check("t2_beat_rvalid", up_if.rvalid, 1);
      check("t2_beat_rdata", up_if.rdata, 32'h100 + b);
      check("t2_beat_rlast", up_if.rlast, (b == 7) ? 1 : 0);
      check("t2_beat_arready", up_if.arready, 0);
      check("t2_beat_mem_arvalid", mem_if.arvalid, 0);
      cyc();
    end
    mem_if.rvalid = 0; mem_if.rlast = 0;
    #1;
    check("t2_after_arready", up_if.arready, 1);
    up_if.arvalid = 0;

    // 3: CONF write while a MEM read burst is in flight
    up_if.araddr = 32'h0000_3000; up_if.arlen = 4'd1; up_if.arvalid = 1;
    cyc();
    up_if.arvalid = 0;
    up_if.awaddr = 32'h1faf_0000; up_if.awlen = 0; up_if.awvalid = 1;
    conf_if.awready = 1; mem_if.awready = 1;
    mem_if.rvalid = 1; mem_if.rdata = 32'h30; mem_if.rlast = 0;
    #1;
    check("t3_conf_awvalid", conf_if.awvalid, 1);
    check("t3_mem_awvalid", mem_if.awvalid, 0);
    check("t3_awready", up_if.awready, 1);
    check("t3_rdata0", up_if.rdata, 32'h30);
    cyc();
    up_if.awvalid = 0;
    up_if.wvalid = 1; up_if.wdata = 32'h55; up_if.wlast = 1;
    conf_if.wready = 1; mem_if.wready = 1;
    mem_if.rdata = 32'h31; mem_if.rlast = 1;
    #1;
    check("t3_conf_wvalid", conf_if.wvalid, 1);
    check("t3_mem_wvalid", mem_if.wvalid, 0);
    check("t3_wready", up_if.wready, 1);
    check("t3_rdata1", up_if.rdata, 32'h31);
    check("t3_rlast", up_if.rlast, 1);
    check("t3_conf_rready", conf_if.rready, 0);
    cyc();
    up_if.wvalid = 0; up_if.wlast = 0; mem_if.rvalid = 0; mem_if.rlast = 0;
    conf_if.bvalid = 1; mem_if.bvalid = 1; up_if.bready = 1;
    #1;
    check("t3_bvalid", up_if.bvalid, 1);
    check("t3_conf_bready", conf_if.bready, 1);
    check("t3_mem_bready", mem_if.bready, 0);
    cyc();
    conf_if.bvalid = 0; mem_if.bvalid = 0;
    #1;
    check("t3_bvalid_idle", up_if.bvalid, 0);

    // 4: W presented 3 cycles before AW is held off
    up_if.wvalid = 1; up_if.wdata = 32'h77; up_if.wlast = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_early_wready", up_if.wready, 0);
      check("t4_early_conf_wvalid", conf_if.wvalid, 0);
      cyc();
    end
    up_if.awaddr = 32'h1faf_0010; up_if.awvalid = 1;
    #1;
    check("t4_aw_wready", up_if.wready, 0);
    check("t4_awready", up_if.awready, 1);
    cyc();
    up_if.awvalid = 0;
    #1;
    check("t4_wready", up_if.wready, 1);
    check("t4_conf_wvalid", conf_if.wvalid, 1);
    check("t4_mem_wvalid", mem_if.wvalid, 0);
    cyc();
    up_if.wvalid = 0; up_if.wlast = 0;
    conf_if.bvalid = 1;
    #1;
    check("t4_bvalid", up_if.bvalid, 1);
    cyc();
    conf_if.bvalid = 0;

    // 5: reset asserted on beat 3 of an 8-beat MEM burst
    up_if.araddr = 32'h0000_2000; up_if.arlen = 4'd7; up_if.arvalid = 1;
    cyc();
    up_if.arvalid = 0;
    mem_if.rvalid = 1; mem_if.rlast = 0;
    for (int b = 0; b < 3; b++) begin
      mem_if.rdata = 32'h200 + b;
      cyc();
    end
    mem_if.rdata = 32'h203;
    up_if.arvalid = 1; up_if.awaddr = 32'h0000_4000; up_if.awvalid = 1;
    aresetn = 0;
    #1;
    check("t5_rvalid", up_if.rvalid, 0);
    check("t5_rdata", up_if.rdata, 0);
    check("t5_mem_rready", mem_if.rready, 0);
    check("t5_arready", up_if.arready, 0);
    check("t5_mem_arvalid", mem_if.arvalid, 0);
    check("t5_awready", up_if.awready, 0);
    check("t5_mem_awvalid", mem_if.awvalid, 0);
    cyc();
    up_if.awvalid = 0; mem_if.rvalid = 0;
    aresetn = 1;
    #1;
    check("t5_fresh_arready", up_if.arready, 1);
    check("t5_fresh_mem_arvalid", mem_if.arvalid, 1);
    cyc();
    up_if.arvalid = 0;
    mem_if.rvalid = 1; mem_if.rdata = 32'h99; mem_if.rlast = 1;
    #1;
    check("t5_fresh_rdata", up_if.rdata, 32'h99);
    check("t5_fresh_rlast", up_if.rlast, 1);
    cyc();
    mem_if.rvalid = 0; mem_if.rlast = 0;

`ifdef DEMUX_DECERR_EN
    // 6: decode error read and write
    up_if.araddr = 32'h4000_0000; up_if.arlen = 4'd3; up_if.arvalid = 1;
    #1;
    check("t6_arready", up_if.arready, 1);
    check("t6_mem_arvalid", mem_if.arvalid, 0);
    check("t6_conf_arvalid", conf_if.arvalid, 0);
    cyc();
    up_if.arvalid = 0;
    up_if.rready = 0;
    #1;
    check("t6_hold_rlast", up_if.rlast, 0);
    cyc();
    up_if.rready = 1;
    for (int b = 0; b < 4; b++) begin
      #1;
      check("t6_rvalid", up_if.rvalid, 1);
      check("t6_rdata", up_if.rdata, 32'hdead_beef);
      check("t6_rlast", up_if.rlast, (b == 3) ? 1 : 0);
      check("t6_mem_rready", mem_if.rready, 0);
      cyc();
    end
    #1;
    check("t6_r_done", up_if.rvalid, 0);
    up_if.awaddr = 32'h4000_0000; up_if.awlen = 4'd1; up_if.awvalid = 1;
    #1;
    check("t6_awready", up_if.awready, 1);
    check("t6_mem_awvalid", mem_if.awvalid, 0);
    cyc();
    up_if.awvalid = 0;
    up_if.wvalid = 1; up_if.wlast = 0; up_if.bready = 0;
    #1;
    check("t6_wready0", up_if.wready, 1);
    check("t6_mem_wvalid", mem_if.wvalid, 0);
    cyc();
    up_if.wlast = 1;
    #1;
    check("t6_wready1", up_if.wready, 1);
    check("t6_bvalid_early", up_if.bvalid, 0);
    cyc();
    up_if.wvalid = 0; up_if.wlast = 0;
    #1;
    check("t6_bvalid", up_if.bvalid, 1);
    up_if.bready = 1;
    cyc();
    #1;
    check("t6_bvalid_done", up_if.bvalid, 0);
`else
    // 6: without the error responder, an unmapped address routes to MEM
    up_if.araddr = 32'h4000_0000; up_if.arlen = 4'd3; up_if.arvalid = 1; mem_if.arready = 0;
    #1;
    check("t6_mem_arvalid", mem_if.arvalid, 1);
    check("t6_conf_arvalid", conf_if.arvalid, 0);
    check("t6_arready_follow", up_if.arready, 0);
    up_if.arvalid = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
